// File: rtl/adc_serial_ctrl.sv
// Serial configuration sequencer for the ADC: 16-bit write/read frames on the
// SEN/SCLK/SDATA/SDOUT port plus the hardware reset pulse and settle wait.
module adc_serial_ctrl #(
  parameter int pCLK_DIV       = 4,
  parameter int pRESET_CYCLES  = 16,
  parameter int pSETTLE_CYCLES = 64
) (
  input  logic       clk_usb,
  input  logic       reset_i,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       init_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  input  logic       ADC_SDOUT,
  output logic       ADC_SEN,
  output logic       ADC_SCLK,
  output logic       ADC_SDATA,
  output logic       ADC_RESET
);

  localparam logic [7:0]  DIV_LAST    = 8'(pCLK_DIV - 1);
  localparam logic [15:0] RST_LAST    = 16'(pRESET_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(pSETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RST_HI, RST_SETTLE, SETUP, SHIFT, HOLD, FIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic        rw_q, rw_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [15:0] seq_q, seq_d;
  logic [7:0]  sh_q, sh_d;
  logic        cap_q, cap_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sen_q, sen_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        adc_rst_q, adc_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    rw_d      = rw_q;
    div_d     = div_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    seq_d     = seq_q;
    sh_d      = sh_q;
    rdata_d   = rdata_q;
    cap_d     = 1'b0;
    sen_d     = 1'b1;
    sclk_d    = 1'b0;
    sdata_d   = 1'b0;
    adc_rst_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    // cap_q trails the state by one cycle, so SDOUT is sampled on the last
    // cycle SCLK is actually high at the pin.
    if (cap_q) sh_d = {sh_q[6:0], ADC_SDOUT};

    case (state_q)
      IDLE: begin
        div_d   = '0;
        seq_d   = '0;
        bit_d   = 4'd15;
        phase_d = 1'b0;
        if (init_req) begin
          state_d = RST_HI;
        end else if (start) begin
          frame_d = {addr, wdata};
          rw_d    = rw;
          state_d = SETUP;
        end
      end
      RST_HI: begin
        busy_d    = 1'b1;
        adc_rst_d = 1'b1;
        if (seq_q == RST_LAST) begin
          seq_d   = '0;
          state_d = RST_SETTLE;
        end else begin
          seq_d = seq_q + 16'd1;
        end
      end
      RST_SETTLE: begin
        busy_d = 1'b1;
        if (seq_q == SETTLE_LAST) state_d = FIN;
        else                      seq_d   = seq_q + 16'd1;
      end
      SETUP: begin
        busy_d  = 1'b1;
        sen_d   = 1'b0;
        sdata_d = frame_q[15];
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        busy_d  = 1'b1;
        sen_d   = 1'b0;
        sclk_d  = phase_q;
        // Read frames drive zeros while the ADC returns the data byte.
        sdata_d = (rw_q && !bit_q[3]) ? 1'b0 : frame_q[bit_q];
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            cap_d = rw_q & ~bit_q[3];
            if (bit_q == 4'd0) state_d = HOLD;
            else               bit_d   = bit_q - 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        busy_d = 1'b1;
        sen_d  = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = FIN;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        if (rw_q) rdata_d = sh_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      rw_q      <= 1'b0;
      div_q     <= '0;
      bit_q     <= 4'd15;
      phase_q   <= 1'b0;
      seq_q     <= '0;
      sh_q      <= '0;
      cap_q     <= 1'b0;
      rdata_q   <= '0;
      sen_q     <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      adc_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      rw_q      <= rw_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      seq_q     <= seq_d;
      sh_q      <= sh_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
      sen_q     <= sen_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      adc_rst_q <= adc_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign ADC_SEN   = sen_q;
  assign ADC_SCLK  = sclk_q;
  assign ADC_SDATA = sdata_q;
  assign ADC_RESET = adc_rst_q;

endmodule
